// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the fetch stage: the fetch
//                FSM state encoding and the default bubble instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   // ISSUE : ready to issue a request at PCF
   // WAIT  : request outstanding, waiting for imem_rvalid
   // DROP  : request outstanding but redirected; its response is discarded
   // HOLD  : response captured while decode was stalled
   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   localparam logic [23:0] DEFAULT_NOP_INSTR = 24'h000000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_stage_register_FD.sv
`default_nettype none
// ============================================================================
//  Module      : register_FD
//  Description : Fetch/decode pipeline register. Clear beats enable; clear
//                loads the bubble instruction and a zero PC+8.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock, rising edge
//    rst        in   asynchronous active-low reset
//    en         in   load enable (deasserted while decode is stalled)
//    clr        in   synchronous clear to bubble
//    instr_d    in   instruction to load
//    pcplus8_d  in   PC+8 to load
//    instr_q    out  registered instruction (InstrD)
//    pcplus8_q  out  registered PC+8 (PCPlus8D)
// ============================================================================
module register_FD
   import fetch_pkg::*;
#(
   parameter int           N         = 24,
   parameter logic [N-1:0] NOP_INSTR = N'(DEFAULT_NOP_INSTR)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [N-1:0] instr_d,
   input  logic [N-1:0] pcplus8_d,
   output logic [N-1:0] instr_q,
   output logic [N-1:0] pcplus8_q
);

   logic [N-1:0] r_instr;
   logic [N-1:0] r_pcplus8;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_instr   <= NOP_INSTR;
         r_pcplus8 <= '0;
      end else if (clr) begin
         r_instr   <= NOP_INSTR;
         r_pcplus8 <= '0;
      end else if (en) begin
         r_instr   <= instr_d;
         r_pcplus8 <= pcplus8_d;
      end
   end

   assign instr_q   = r_instr;
   assign pcplus8_q = r_pcplus8;

endmodule : register_FD
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Pipeline fetch stage. Owns the PC and next-PC selection,
//                runs a single-outstanding-request instruction-memory
//                handshake and feeds the fetch/decode pipeline register.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk           in   clock, rising edge
//    rst           in   asynchronous active-low reset
//    StallF        in   freeze PC, no new request
//    StallD        in   hold fetch/decode register
//    FlushD        in   load bubble into fetch/decode register
//    BranchTakenE  in   early branch redirect from execute (higher priority)
//    ALUResultE    in   branch target from execute
//    PCSrcW        in   PC write from writeback
//    ResultW       in   PC target from writeback
//    imem_req      out  request strobe, one cycle per request
//    imem_addr     out  request address (= PCF)
//    imem_rvalid   in   response valid
//    imem_rdata    in   instruction word
//    InstrD        out  instruction to decode
//    PCPlus8D      out  fetched PC + 2*PC_STEP
//    PCF           out  current fetch PC
//    FetchBusy     out  request outstanding (WAIT or DROP)
// ============================================================================
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int           N         = 24,
   parameter int           PC_STEP   = 4,
   parameter logic [N-1:0] RESET_PC  = '0,
   parameter logic [N-1:0] NOP_INSTR = N'(DEFAULT_NOP_INSTR)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         StallF,
   input  logic         StallD,
   input  logic         FlushD,
   input  logic         BranchTakenE,
   input  logic [N-1:0] ALUResultE,
   input  logic         PCSrcW,
   input  logic [N-1:0] ResultW,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_rvalid,
   input  logic [N-1:0] imem_rdata,
   output logic [N-1:0] InstrD,
   output logic [N-1:0] PCPlus8D,
   output logic [N-1:0] PCF,
   output logic         FetchBusy
);

   localparam logic [N-1:0] C_STEP  = N'(PC_STEP);
   localparam logic [N-1:0] C_STEP2 = N'(2 * PC_STEP);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   logic [N-1:0] r_pcf;
   logic [N-1:0] r_buf_instr;
   logic [N-1:0] r_buf_pc8;

   logic         w_redir;
   logic [N-1:0] w_target;
   logic [N-1:0] w_pc_seq;
   logic [N-1:0] w_pc_plus8;

   logic         w_req;
   logic         w_pc_load;
   logic [N-1:0] w_pc_val;
   logic         w_buf_load;
   logic [N-1:0] w_fd_instr;
   logic [N-1:0] w_fd_pc8;

   // Execute-stage branch outranks the writeback PC write.
   assign w_redir    = BranchTakenE | PCSrcW;
   assign w_target   = BranchTakenE ? ALUResultE : ResultW;
   assign w_pc_seq   = r_pcf + C_STEP;
   assign w_pc_plus8 = r_pcf + C_STEP2;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ISSUE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ISSUE: begin
            if (!w_redir && !StallF) begin
               w_state_next = WAIT;
            end
         end
         WAIT: begin
            if (w_redir) begin
               w_state_next = imem_rvalid ? ISSUE : DROP;
            end else if (imem_rvalid) begin
               w_state_next = StallD ? HOLD : ISSUE;
            end
         end
         DROP: begin
            // The stale response retires the outstanding request even if
            // another redirect lands in the same cycle.
            if (imem_rvalid) begin
               w_state_next = ISSUE;
            end
         end
         HOLD: begin
            if (w_redir || FlushD || !StallD) begin
               w_state_next = ISSUE;
            end
         end
         default: w_state_next = ISSUE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath control logic
   // ------------------------------------------------------------------
   always_comb begin
      w_req      = 1'b0;
      w_pc_load  = 1'b0;
      w_pc_val   = r_pcf;
      w_buf_load = 1'b0;
      w_fd_instr = NOP_INSTR;
      w_fd_pc8   = '0;
      case (r_state)
         ISSUE: begin
            w_req = !StallF && !w_redir;
            if (w_redir) begin
               w_pc_load = 1'b1;
               w_pc_val  = w_target;
            end
         end
         WAIT: begin
            if (w_redir) begin
               w_pc_load = 1'b1;
               w_pc_val  = w_target;
            end else if (imem_rvalid) begin
               if (!StallD) begin
                  w_fd_instr = imem_rdata;
                  w_fd_pc8   = w_pc_plus8;
                  w_pc_load  = 1'b1;
                  w_pc_val   = w_pc_seq;
               end else begin
                  w_buf_load = 1'b1;
               end
            end
         end
         DROP: begin
            if (w_redir) begin
               w_pc_load = 1'b1;
               w_pc_val  = w_target;
            end
         end
         HOLD: begin
            if (w_redir) begin
               w_pc_load = 1'b1;
               w_pc_val  = w_target;
            end else if (!FlushD && !StallD) begin
               w_fd_instr = r_buf_instr;
               w_fd_pc8   = r_buf_pc8;
               w_pc_load  = 1'b1;
               w_pc_val   = w_pc_seq;
            end
         end
         default: ;
      endcase
   end

   // Request is gated by reset so nothing is issued while held in reset.
   assign imem_req  = rst & w_req;
   assign imem_addr = r_pcf;
   assign PCF       = r_pcf;
   assign FetchBusy = (r_state == WAIT) || (r_state == DROP);

   // ------------------------------------------------------------------
   // PC register and hold buffer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pcf <= RESET_PC;
      end else if (w_pc_load) begin
         r_pcf <= w_pc_val;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf_instr <= NOP_INSTR;
         r_buf_pc8   <= '0;
      end else if (w_buf_load) begin
         r_buf_instr <= imem_rdata;
         r_buf_pc8   <= w_pc_plus8;
      end
   end

   // ------------------------------------------------------------------
   // Fetch/decode pipeline register
   // ------------------------------------------------------------------
   register_FD #(
      .N         (N),
      .NOP_INSTR (NOP_INSTR)
   ) u_register_fd (
      .clk       (clk),
      .rst       (rst),
      .en        (!StallD),
      .clr       (FlushD),
      .instr_d   (w_fd_instr),
      .pcplus8_d (w_fd_pc8),
      .instr_q   (InstrD),
      .pcplus8_q (PCPlus8D)
   );

endmodule : fetch_stage
`default_nettype wire
